// File: rtl/demux1to4_8bit_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux1to4_8bit_reg
//  Description : 1-to-4 registered demultiplexer with per-slot valid/consume
//                handshake, sticky per-slot overflow flags, and a wrapping
//                count of accepted writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1to4_8bit_reg #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] In,
  input  logic [1:0]   S,
  input  logic         WE,
  input  logic [3:0]   Ack,
  input  logic         ClrOvf,
  output logic [W-1:0] Out0,
  output logic [W-1:0] Out1,
  output logic [W-1:0] Out2,
  output logic [W-1:0] Out3,
  output logic [3:0]   Valid,
  output logic [3:0]   Ovf,
  output logic         Full,
  output logic [7:0]   WrCount
);

  // Each slot is an independent two-state machine; Valid is the state itself.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  slot_state_t  state_q [4];
  slot_state_t  state_d [4];
  logic [W-1:0] data_q  [4];
  logic [W-1:0] data_d  [4];
  logic [3:0]   ovf_q;
  logic [3:0]   ovf_d;
  logic [7:0]   wrcnt_q;
  logic [7:0]   wrcnt_d;

  // State register: asynchronous reset clears all slots, flags and the count.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_EMPTY;
        data_q[i]  <= '0;
      end
      ovf_q   <= '0;
      wrcnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
      ovf_q   <= ovf_d;
      wrcnt_q <= wrcnt_d;
    end
  end

  // Next-state logic: write beats release, a blocked write sets the sticky
  // overflow bit, and that set wins over a simultaneous clear.
  always_comb begin
    logic accepted;
    logic wr_hit;
    accepted = 1'b0;
    wr_hit   = 1'b0;
    ovf_d    = ClrOvf ? 4'b0000 : ovf_q;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      wr_hit     = WE && (S == 2'(i));
      case (state_q[i])
        ST_EMPTY: begin
          // Ack on an empty slot has no effect.
          if (wr_hit) begin
            data_d[i]  = In;
            state_d[i] = ST_FULL;
            accepted   = 1'b1;
          end
        end
        ST_FULL: begin
          if (wr_hit && Ack[i]) begin
            // Consumer releases and producer refills in the same cycle.
            data_d[i] = In;
            accepted  = 1'b1;
          end else if (wr_hit) begin
            ovf_d[i] = 1'b1;
          end else if (Ack[i]) begin
            state_d[i] = ST_EMPTY;
          end
        end
        default: state_d[i] = ST_EMPTY;
      endcase
    end
    wrcnt_d = accepted ? (wrcnt_q + 8'd1) : wrcnt_q;
  end

  // Output mapping: Full is the only combinational output, derived from Valid.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      Valid[i] = (state_q[i] == ST_FULL);
    end
    Full    = &Valid;
    Out0    = data_q[0];
    Out1    = data_q[1];
    Out2    = data_q[2];
    Out3    = data_q[3];
    Ovf     = ovf_q;
    WrCount = wrcnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_demux1to4_8bit_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1to4_8bit_reg
//  Description : Scoreboard bench for demux1to4_8bit_reg. Stimulus pushes the
//                reference model's expected outputs; a monitor pops and
//                compares one entry after each rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1to4_8bit_reg;

  typedef struct packed {
    logic [3:0][7:0] out;
    logic [3:0]      valid;
    logic [3:0]      ovf;
    logic            full;
    logic [7:0]      cnt;
  } exp_t;

  logic       clk;
  logic       Reset;
  logic [7:0] In;
  logic [1:0] S;
  logic       WE;
  logic [3:0] Ack;
  logic       ClrOvf;
  logic [7:0] Out0, Out1, Out2, Out3;
  logic [3:0] Valid, Ovf;
  logic       Full;
  logic [7:0] WrCount;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  // Reference model: slot contents, occupancy, sticky flags, accepted count.
  logic [7:0] m_data [4];
  logic       m_val  [4];
  logic       m_ovf  [4];
  int         m_cnt;

  demux1to4_8bit_reg #(.W(8)) dut (
    .Clk(clk), .Reset(Reset), .In(In), .S(S), .WE(WE), .Ack(Ack),
    .ClrOvf(ClrOvf), .Out0(Out0), .Out1(Out1), .Out2(Out2), .Out3(Out3),
    .Valid(Valid), .Ovf(Ovf), .Full(Full), .WrCount(WrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    int nval;
    nval = 0;
    for (int i = 0; i < 4; i++) begin
      e.out[i]   = m_data[i];
      e.valid[i] = m_val[i];
      e.ovf[i]   = m_ovf[i];
      if (m_val[i]) nval++;
    end
    e.full = (nval == 4);
    e.cnt  = 8'(m_cnt % 256);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 8'h00;
      m_val[i]  = 1'b0;
      m_ovf[i]  = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, "_out0"},  32'(Out0),    32'(e.out[0]));
    chk({tag, "_out1"},  32'(Out1),    32'(e.out[1]));
    chk({tag, "_out2"},  32'(Out2),    32'(e.out[2]));
    chk({tag, "_out3"},  32'(Out3),    32'(e.out[3]));
    chk({tag, "_valid"}, 32'(Valid),   32'(e.valid));
    chk({tag, "_ovf"},   32'(Ovf),     32'(e.ovf));
    chk({tag, "_full"},  32'(Full),    32'(e.full));
    chk({tag, "_cnt"},   32'(WrCount), 32'(e.cnt));
  endtask

  // One clock of stimulus: drive at the falling edge, advance the model,
  // and queue what the DUT must show after the following rising edge.
  task automatic step(input logic we, input logic [1:0] s, input logic [7:0] d,
                      input logic [3:0] ack, input logic clr);
    @(negedge clk);
    WE = we; S = s; In = d; Ack = ack; ClrOvf = clr;
    if (clr) for (int i = 0; i < 4; i++) m_ovf[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (we && int'(s) == i) begin
        if (!m_val[i] || ack[i]) begin
          m_data[i] = d;
          m_val[i]  = 1'b1;
          m_cnt++;
        end else begin
          m_ovf[i] = 1'b1;
        end
      end else if (ack[i]) begin
        m_val[i] = 1'b0;
      end
    end
    q.push_back(snapshot());
  endtask

  // Reset asserted mid-cycle with a write and acks presented; outputs must
  // clear at once and stay clear across the edge seen while in reset.
  task automatic async_reset();
    @(negedge clk);
    #2;
    Reset = 1'b1; WE = 1'b1; S = 2'd0; In = 8'hEE; Ack = 4'hF; ClrOvf = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst", snapshot());
    q.push_back(snapshot());
    @(negedge clk);
    Reset = 1'b0; WE = 1'b0; Ack = 4'h0;
  endtask

  // Monitor: outputs are always presented; compare one queued entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_outputs("sb", e);
      end
    end
  end

  initial begin
    Reset = 1'b1; WE = 1'b0; S = 2'd0; In = 8'h00; Ack = 4'h0; ClrOvf = 1'b0;
    model_reset();
    #1;
    check_outputs("reset", snapshot());
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;

    // Single write to slot 2
    step(1'b1, 2'd2, 8'hA5, 4'h0, 1'b0);
    // Clear and exercise drop / overflow / clear on slot 1
    step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
    step(1'b1, 2'd1, 8'h11, 4'h0, 1'b0);
    step(1'b1, 2'd1, 8'h22, 4'h0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 4'h0, 1'b1);
    // Write with simultaneous ack on full slot 3
    step(1'b1, 2'd3, 8'h33, 4'h0, 1'b0);
    step(1'b1, 2'd3, 8'h44, 4'b1000, 1'b0);
    // Drop coinciding with clear: set wins
    step(1'b1, 2'd3, 8'h55, 4'h0, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'h0, 1'b1);
    // Fill all four, then release all at once
    step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 8'(8'h10 + i), 4'h0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
    step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);

    // 256 accepted writes from a zero count: count must wrap back to 0
    async_reset();
    for (int i = 0; i < 256; i++) begin
      if (m_val[i % 2]) step(1'b0, 2'd0, 8'h00, 4'(1 << (i % 2)), 1'b0);
      step(1'b1, 2'(i % 2), 8'(i), 4'h0, 1'b0);
    end
    chk("wrap_model", 32'(m_cnt), 32'd256);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
           4'($urandom) & 4'($urandom), 1'($urandom_range(0, 9) == 0));
    end

    // Reset between edges while slots 0 and 2 hold data
    step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
    step(1'b1, 2'd0, 8'h5A, 4'h0, 1'b0);
    step(1'b1, 2'd2, 8'hC3, 4'h0, 1'b0);
    async_reset();
    step(1'b1, 2'd1, 8'h77, 4'h0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/demux1to4_8bit_reg.md
DEMUX1TO4_8BIT_REG -- requirements
Module: demux1to4_8bit_reg

Interface
REQ-001 SHALL have parameter W, default 8, data width of the input and of each output slot.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port In, input, W, write data.
REQ-005 SHALL have port S, input, 2, destination slot select (0..3).
REQ-006 SHALL have port WE, input, 1, write strobe, sampled each rising Clk edge.
REQ-007 SHALL have port Ack, input, 4, per-slot consume strobe; bit i releases slot i.
REQ-008 SHALL have port ClrOvf, input, 1, synchronous clear of all overflow flags.
REQ-009 SHALL have ports Out0, Out1, Out2, Out3, output, W each, registered slot data.
REQ-010 SHALL have port Valid, output, 4, bit i set means slot i holds unconsumed data.
REQ-011 SHALL have port Ovf, output, 4, sticky per-slot dropped-write flag.
REQ-012 SHALL have port Full, output, 1, high when all four Valid bits are 1.
REQ-013 SHALL have port WrCount, output, 8, count of accepted writes.

Function
REQ-014 SHALL implement, per slot i, a two-state machine: EMPTY (Valid[i]=0) and FULL (Valid[i]=1).
REQ-015 SHALL accept a write, when WE=1 and S=i and slot i is EMPTY, by loading In into Out_i and moving slot i to FULL at the same edge, giving 1-cycle latency.
REQ-016 SHALL accept a write, when WE=1, S=i, slot i is FULL and Ack[i]=1 in the same cycle, by loading In into Out_i with slot i remaining FULL; the write takes priority over the release.
REQ-017 SHALL drop a write, when WE=1, S=i, slot i is FULL and Ack[i]=0: Out_i and Valid[i] stay unchanged and Ovf[i] is set to 1.
REQ-018 SHALL move slot i from FULL to EMPTY when Ack[i]=1 and slot i is not being written that cycle; Out_i keeps its last value.
REQ-019 SHALL ignore Ack[i] while slot i is EMPTY, with no state change.
REQ-020 SHALL allow all four Ack bits to act in the same cycle, with each bit applied independently.
REQ-021 SHALL leave slots j != S unaffected by a write, apart from their own Ack[j].
REQ-022 SHALL hold Ovf[i] at 1 until ClrOvf=1 or Reset.
REQ-023 SHALL clear all Ovf bits when ClrOvf=1; if a drop on slot i occurs in the same cycle, Ovf[i] SHALL read 1 after the edge (set wins).
REQ-024 SHALL increment WrCount by 1 for each accepted write only (REQ-015, REQ-016), wrapping from 255 to 0; dropped writes SHALL NOT count.
REQ-025 SHALL derive Full combinationally from Valid; all other outputs SHALL be registered.
REQ-026 SHALL perform no state change when WE=0 and Ack=0 and ClrOvf=0.

Reset
REQ-027 SHALL, while Reset=1 and independent of Clk, force Out0..Out3=0, Valid=0, Ovf=0, WrCount=0 and Full=0.
REQ-028 SHALL discard any write or Ack presented in a cycle in which Reset is asserted, including a reset that arrives while slots are FULL.
REQ-029 SHALL resume normal operation at the first rising Clk edge after Reset deasserts.

Verification
REQ-030 Reset, then WE=1, S=2, In=0xA5 for one cycle: after the edge Out2=0xA5, Valid=4'b0100, WrCount=1, and all other outputs are 0.
REQ-031 Slot 1 FULL with 0x11, then WE=1, S=1, In=0x22, Ack=0: Out1=0x11, Ovf=4'b0010, WrCount unchanged; then ClrOvf=1 gives Ovf=0.
REQ-032 Slot 3 FULL with 0x33, then WE=1, S=3, In=0x44, Ack=4'b1000 in the same cycle: Out3=0x44, Valid[3]=1, WrCount+1, Ovf[3]=0.
REQ-033 Fill slots 0..3 with 0x10..0x13, giving Full=1; then Ack=4'b1111 for one cycle: Valid=0, Full=0, Out0..Out3 still 0x10..0x13.
REQ-034 Perform 256 accepted writes alternating slot with an Ack before each rewrite: WrCount returns to 0.
REQ-035 With slots 0 and 2 FULL, assert Reset between Clk edges: all outputs read 0 immediately, before the next edge.
